// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver clocked at OVERSAMPLE x baud.
// Synchronises the RX line, finds the start bit, samples each bit once at its centre and
// presents the byte through a valid/read handshake. Framing errors and overruns are
// reported as one-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after bit 7 and an
// o_parity_err pulse output; a byte with bad parity is discarded.
module uart_rx #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_uart_clk,
    input  logic       i_reset,
    input  logic       i_uart_rx,
    input  logic       i_read,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_overrun
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);

    // StParity is only reachable when the parity feature is compiled in.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             perr_q, perr_d;
`endif

    // Input synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge i_uart_clk) begin
        if (i_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // State, counters, shift register and output registers.
    always_ff @(posedge i_uart_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Next-state logic: frame sequencing, bit-centre sampling and handshake.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif

        // Consumer acknowledge; a byte completing this cycle overrides it below.
        if (i_read && valid_q) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end

            StStart: begin
                if (tick_q == HalfLast) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    // Line back high at the start-bit centre means a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            StData: begin
                if (tick_q == FullLast) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick_q == FullLast) begin
                    tick_d    = '0;
                    par_bad_d = ^{shift_q, rx_s};
                    perr_d    = ^{shift_q, rx_s};
                    state_d   = StStop;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif

            StStop: begin
                if (tick_q == FullLast) begin
                    tick_d = '0;
                    if (rx_s) begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (!par_bad_q) begin
`else
                        begin
`endif
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            // A same-cycle read consumes the old byte, so no overrun.
                            if (valid_q && !i_read) begin
                                ovr_d = 1'b1;
                            end
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            StWaitHigh: begin
                tick_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_busy      = (state_q != StIdle);
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at OVERSAMPLE=16, SYNC_STAGES=2: table of 8N1 frames plus
// hand-written sequences for latency, glitch rejection, held-low framing error and reset.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       ferr;
    logic       ovr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;

    uart_rx #(
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2)
    ) dut (
        .i_uart_clk (clk),
        .i_reset    (rst),
        .i_uart_rx  (rx),
        .i_read     (rd),
        .o_data     (data),
        .o_valid    (valid),
        .o_busy     (busy),
        .o_frame_err(ferr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(perr),
`endif
        .o_overrun  (ovr)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (ovr) ovr_cnt++;
        if (ferr) ferr_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       read_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_ovr;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        step(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) hold(d[i], OS);
        hold(stop_bit, OS);
        rx = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int base_o;
        int base_f;

        //                data   stop  read  exp_d  exp_v ovr ferr
        vecs[0] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 0, 0};
        vecs[1] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 0, 0};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 0, 0};
        vecs[3] = '{8'h02, 1'b1, 1'b0, 8'h02, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h02, 1'b1, 0, 1};

        // Reset state.
        step(3);
        rst = 1'b0;
        step(2);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_ovr", 32'(ovr), 0);

        // 0x55 with latency measurement from the falling edge.
        base_o = ovr_cnt;
        base_f = ferr_cnt;
        lat = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (!valid && lat < 300) begin
                    step(1);
                    lat++;
                end
            end
        join
        checks++;
        if (lat < 153 || lat > 155) begin
            errors++;
            $display("FAIL latency actual=%0d expected=154+-1", lat);
        end
        hold(1'b1, 20);
        check("f55_data", 32'(data), 32'h55);
        check("f55_valid", 32'(valid), 1);
        check("f55_busy", 32'(busy), 0);
        check("f55_ovr", 32'(ovr_cnt - base_o), 0);
        check("f55_ferr", 32'(ferr_cnt - base_f), 0);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        check("f55_read_clr", 32'(valid), 0);

        // Glitch: 6 cycles low is rejected at the start-bit centre.
        base_o = ovr_cnt;
        base_f = ferr_cnt;
        hold(1'b0, 6);
        hold(1'b1, 30);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_valid", 32'(valid), 0);
        check("glitch_flags", 32'((ovr_cnt - base_o) + (ferr_cnt - base_f)), 0);

        // Table of frames.
        for (int i = 0; i < 5; i++) begin
            base_o = ovr_cnt;
            base_f = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            hold(1'b1, 20);
            check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ovr", i), 32'(ovr_cnt - base_o), 32'(vecs[i].exp_ovr));
            check($sformatf("v%0d_ferr", i), 32'(ferr_cnt - base_f), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_busy", i), 32'(busy), 0);
            if (vecs[i].read_after) begin
                rd = 1'b1;
                step(1);
                rd = 1'b0;
                check($sformatf("v%0d_read_clr", i), 32'(valid), 0);
            end
        end

        // 0x3C with stop low and line held low: one frame error, stays busy until high.
        base_f = ferr_cnt;
        hold(1'b0, OS);
        for (int i = 0; i < 8; i++) hold(1'((8'h3C >> i) & 8'h01), OS);
        hold(1'b0, 40);
        check("held_ferr", 32'(ferr_cnt - base_f), 1);
        check("held_busy", 32'(busy), 1);
        check("held_data", 32'(data), 32'h02);
        check("held_valid", 32'(valid), 0);
        hold(1'b1, 10);
        check("held_release_busy", 32'(busy), 0);
        check("held_ferr_once", 32'(ferr_cnt - base_f), 1);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 20);
        check("recover_data", 32'(data), 32'h5A);
        check("recover_valid", 32'(valid), 1);

        // Reset mid-DATA of 0xFF, then 0x81.
        hold(1'b0, OS);
        hold(1'b1, 40);
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_flags", 32'({ferr, ovr}), 0);
        hold(1'b1, 40);
        check("midrst_quiet_valid", 32'(valid), 0);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 20);
        check("f81_data", 32'(data), 32'h81);
        check("f81_valid", 32'(valid), 1);
        check("f81_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of uart_tx.
- Clocked at OVERSAMPLE x baud rate, from the same uart_clock divider family.
- Synchronises the asynchronous RX line, finds the start bit, samples each bit at mid-period and presents the byte through a valid/read handshake.
- Flags framing errors and overruns.

Parameters:
OVERSAMPLE, 16, clock ticks per bit period; even, >= 4
SYNC_STAGES, 2, flip-flops in the RX input synchroniser; >= 2

Ports:
i_uart_clk  input  1  receiver clock, OVERSAMPLE x baud
i_reset  input  1  synchronous, active-high reset
i_uart_rx  input  1  serial line, idle high, asynchronous
i_read  input  1  consumer acknowledges o_data; clears o_valid
o_data  output  8  last good received byte
o_valid  output  1  o_data holds an unread byte
o_busy  output  1  frame reception in progress (state != IDLE)
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: byte completed while o_valid already high

Behaviour:
- Reset (synchronous, i_reset high at clock edge):
  - Synchroniser flops set to 1; state = IDLE; counters cleared.
  - o_data=8'h00; o_valid, o_busy, o_frame_err and o_overrun = 0.
  - Reset mid-frame aborts the frame; no output pulse.
- Synchroniser: SYNC_STAGES flops; rx_s is the last stage. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 -> START; tick counter = 0.
  - o_busy goes high the cycle after entry to START.
- START:
  - Count OVERSAMPLE/2 ticks, then sample rx_s.
  - 0 -> DATA; tick and bit counters cleared.
  - 1 -> IDLE (glitch rejected, no flags).
- DATA:
  - Every OVERSAMPLE ticks sample rx_s into the shift register, LSB first.
  - After bit 7 -> STOP.
- STOP (bit 9, no parity): after OVERSAMPLE ticks sample rx_s.
  - 1 -> o_data <= shift register; o_valid <= 1; state -> IDLE.
  - If o_valid was already 1 and i_read is low that cycle: o_overrun pulses, new byte overwrites o_data.
  - 0 -> o_frame_err pulses; o_data and o_valid unchanged; state -> WAIT_HIGH.
- WAIT_HIGH: stays until rx_s==1, then -> IDLE. Covers break conditions and prevents a false start on a held-low line.
- Handshake:
  - o_valid is a level. i_read while o_valid high clears it next cycle.
  - i_read while o_valid low is ignored.
  - i_read in the same cycle a byte completes: new byte loaded, o_valid stays 1, no overrun.
- Latency: o_valid rises SYNC_STAGES + OVERSAMPLE/2 + 9*OVERSAMPLE cycles (+-1) after the RX falling edge.
- Counters:
  - Tick counter width is clog2(OVERSAMPLE); bit counter is 3 bits.
  - Both wrap cleanly and are reset at each state entry.
- Sampling: single sample at bit centre; no majority vote.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - An even-parity bit follows bit 7 and is sampled in an extra PARITY state before STOP.
  - New output o_parity_err: one-cycle pulse when the XOR of the 8 data bits and the parity bit is 1.
  - On parity error the byte is still discarded (o_valid and o_data unchanged); the stop bit is still checked.
  - Latency grows by OVERSAMPLE.
- Undefined:
  - No PARITY state and no o_parity_err port; 8N1 only.

Test Plan:
- Reset, then 8N1 frame 0x55 at 16 ticks/bit (OVERSAMPLE=16) -> o_data=8'h55, o_valid rises 154+-1 cycles after the falling edge, o_busy low afterwards, no error pulses.
- Back-to-back frames 0xA3 then 0x0F, i_read pulsed after each -> two o_valid events with correct data, no overrun.
- Frames 0x01 then 0x02 with no i_read -> o_overrun pulses once, o_data=8'h02, o_valid stays 1.
- Line low for 6 cycles then high (glitch) -> no o_busy after return to IDLE, no o_valid, no flags.
- Frame 0x3C with stop bit driven low, line held low 40 cycles -> o_frame_err pulses once, o_data keeps prior value, no new start until the line returns high.
- i_reset asserted mid-DATA of frame 0xFF -> all outputs 0 on the next cycle; a following frame 0x81 receives correctly.
